frame_receiver: RTL and testbench
=================================

FRAME_RECEIVER -- requirements
Module: frame_receiver

Interface
REQ-001 SHALL have parameter DATA_W, default 8, column data byte width.
REQ-002 SHALL have parameter LEN_W, default 16, width of byte/column counts.
REQ-003 SHALL have parameter MIN_CCLK, default 8, minimum legal CCLK high width in ti_clk cycles.
REQ-004 SHALL have port ti_clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port reg_length  input  LEN_W  bytes per column.
REQ-007 SHALL have port reg_cols  input  LEN_W  columns per frame.
REQ-008 SHALL have port FRAME  input  1  single-cycle frame start pulse.
REQ-009 SHALL have port CCLK  input  1  column clock, end-of-column marker.
REQ-010 SHALL have port din / din_valid  input  DATA_W / 1  column byte and its qualifier.
REQ-011 SHALL have port err_clr  input  1  clears sticky errors.
REQ-012 SHALL have port wr_en / wr_addr / wr_data  output  1 / LEN_W / DATA_W  column buffer write port.
REQ-013 SHALL have port col_done / col_index  output  1 / LEN_W  column commit pulse and its zero-based index.
REQ-014 SHALL have port frame_done / busy  output  1 / 1  end-of-frame pulse; receiver not IDLE.
REQ-015 SHALL have port err_len / err_cclk / err_frame  output  1 each  sticky error flags.

Function
REQ-016 SHALL run FSM states IDLE, LOAD, CCLK_HI, DONE; all inputs synchronous to ti_clk.
REQ-017 IDLE: FRAME=1 with reg_length!=0 and reg_cols!=0 SHALL latch both, clear byte_cnt and col_cnt, go LOAD next cycle; FRAME with either zero SHALL be ignored.
REQ-018 LOAD: din_valid=1 with byte_cnt<len SHALL assert wr_en next cycle with wr_addr=byte_cnt, wr_data=din, then byte_cnt+1 (1-cycle latency).
REQ-019 LOAD: din_valid=1 with byte_cnt==len SHALL drop the byte, no wr_en, set err_len.
REQ-020 LOAD: CCLK rising edge SHALL enter CCLK_HI, width counter=1; byte_cnt!=len at that edge SHALL set err_len.
REQ-021 CCLK_HI: width counter SHALL increment per high cycle, saturating at 255; din_valid ignored.
REQ-022 CCLK_HI: CCLK falling edge with width<MIN_CCLK SHALL set err_cclk; column still commits.
REQ-023 Commit SHALL pulse col_done one cycle with col_index=col_cnt, then col_cnt+1; if col_cnt+1==cols go DONE, else LOAD with byte_cnt=0.
REQ-024 DONE SHALL pulse frame_done one cycle and return IDLE.
REQ-025 FRAME in LOAD or CCLK_HI SHALL set err_frame and restart LOAD with both counters cleared and new reg values latched.
REQ-026 din_valid and CCLK rising in same LOAD cycle SHALL write the byte first, then count it in the length check.
REQ-027 err_clr SHALL clear all sticky errors; a same-cycle new error SHALL win.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, counters 0, all outputs 0, errors cleared; reset mid-frame discards the partial column without col_done.

Configuration
REQ-029 With FRAME_RX_CHECKSUM_EN defined SHALL add output col_sum [DATA_W-1:0], XOR of all written bytes of the column, valid with col_done, cleared per column.
REQ-030 Without FRAME_RX_CHECKSUM_EN port col_sum and its logic SHALL be absent.

Structure
REQ-031 Package frame_pkg SHALL hold FSM state enum, MIN_CCLK default, width-counter width (8).
REQ-032 Sub-module frame_rx_cclk SHALL register CCLK, produce rise/fall strobes and saturating width count.

Verification
REQ-033 len=4, cols=3, FRAME, 4 bytes + 24-cycle CCLK per column -> 12 writes, col_done idx 0,1,2, one frame_done, no errors.
REQ-034 len=4, only 3 bytes before CCLK -> err_len=1, col_done still pulses, wr_addr max 2.
REQ-035 CCLK high 5 cycles, MIN_CCLK=8 -> err_cclk=1 after fall, column committed.
REQ-036 FRAME re-pulsed after column 1 bytes 0-1 -> err_frame=1, next write wr_addr=0, col_index restarts 0.
REQ-037 rst_n low mid-LOAD -> busy=0, no col_done; following clean frame completes normally.
REQ-038 With FRAME_RX_CHECKSUM_EN, bytes 0x12,0x34,0x56,0x78 -> col_sum=0x08 at col_done.

Source files
------------

// File: rtl/frame_pkg.sv
// Shared definitions for the frame receiver: FSM state encoding, the
// default minimum CCLK high width, and the CCLK width-counter geometry.
package frame_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_CCLK_HI = 2'd2,
    ST_DONE    = 2'd3
  } frame_state_e;

  // Default minimum legal CCLK high width, in ti_clk cycles.
  localparam int MIN_CCLK_DEFAULT = 8;

  // The CCLK high-width counter is 8 bits wide and saturates at its top value.
  localparam int                    CCLK_CNT_W   = 8;
  localparam logic [CCLK_CNT_W-1:0] CCLK_CNT_MAX = '1;

  // Saturating increment for the CCLK width counter.
  function automatic logic [CCLK_CNT_W-1:0] sat_inc(input logic [CCLK_CNT_W-1:0] v);
    return (v == CCLK_CNT_MAX) ? v : v + CCLK_CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_rx_cclk.sv
// CCLK edge detector for the frame receiver.
// Registers CCLK once, produces single-cycle rise/fall strobes in the cycle
// where the new level is first seen, and counts the high width.
// width reads 1 in the cycle after the rising edge, and in the falling-edge
// cycle it equals the number of cycles CCLK was high (saturating at 255).
module frame_rx_cclk
  import frame_pkg::*;
(
  input  logic                  ti_clk,
  input  logic                  rst_n,
  input  logic                  cclk,
  output logic                  rise,
  output logic                  fall,
  output logic [CCLK_CNT_W-1:0] width
);

  logic cclk_q;

  // Previous-cycle CCLK level used for edge detection.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      cclk_q <= 1'b0;
    end else begin
      cclk_q <= cclk;
    end
  end

  assign rise = cclk & ~cclk_q;
  assign fall = ~cclk & cclk_q;

  // High-width counter: restarts at 1 on a rising edge, then counts every
  // further high cycle until it saturates.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      width <= '0;
    end else if (rise) begin
      width <= CCLK_CNT_W'(1);
    end else if (cclk && cclk_q) begin
      width <= sat_inc(width);
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Frame receiver: collects reg_length bytes per column for reg_cols columns.
// Each column ends with a CCLK pulse.
// The received bytes are written to a column buffer through the wr_* port.
// col_done pulses when a column commits and frame_done pulses at the end of the frame.
// Protocol problems raise the sticky flags err_len, err_cclk and err_frame.
// Optional feature: define FRAME_RX_CHECKSUM_EN to add the col_sum output,
// which gives the XOR of the bytes written in each column.
//
// Input qualifier semantics: din is consumed in every LOAD cycle where
// din_valid is high. There is no back-pressure, so the source never waits.
// Bytes beyond the latched length are dropped and flagged. Bytes seen while
// CCLK is high, or outside a frame, are ignored.
module frame_receiver
  import frame_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 16,
  parameter int MIN_CCLK = MIN_CCLK_DEFAULT
) (
  input  logic              ti_clk,
  input  logic              rst_n,
  input  logic [LEN_W-1:0]  reg_length,
  input  logic [LEN_W-1:0]  reg_cols,
  input  logic              FRAME,
  input  logic              CCLK,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  input  logic              err_clr,
  output logic              wr_en,
  output logic [LEN_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              col_done,
  output logic [LEN_W-1:0]  col_index,
  output logic              frame_done,
  output logic              busy,
  output logic              err_len,
  output logic              err_cclk,
  output logic              err_frame,
  output logic [1:0]        fsm_state
`ifdef FRAME_RX_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] col_sum
`endif
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] LOAD    = ST_LOAD;
  localparam logic [1:0] CCLK_HI = ST_CCLK_HI;
  localparam logic [1:0] DONE    = ST_DONE;

  logic [1:0]            state_q, state_n;
  logic [LEN_W-1:0]      len_q, len_n;
  logic [LEN_W-1:0]      cols_q, cols_n;
  logic [LEN_W-1:0]      byte_cnt, byte_cnt_n;
  logic [LEN_W-1:0]      col_cnt, col_cnt_n;

  logic                  wr_en_n;
  logic [LEN_W-1:0]      wr_addr_n;
  logic [DATA_W-1:0]     wr_data_n;
  logic                  col_done_n;
  logic [LEN_W-1:0]      col_index_n;
  logic                  frame_done_n;

  logic                  set_len, set_cclk, set_frame;
  logic                  restart, commit;
  logic                  frame_ok;

  logic                  cclk_rise, cclk_fall;
  logic [CCLK_CNT_W-1:0] cclk_width;

  frame_rx_cclk u_cclk (
    .ti_clk (ti_clk),
    .rst_n  (rst_n),
    .cclk   (CCLK),
    .rise   (cclk_rise),
    .fall   (cclk_fall),
    .width  (cclk_width)
  );

  assign frame_ok  = (reg_length != '0) && (reg_cols != '0);
  assign busy      = (state_q != IDLE);
  assign fsm_state = state_q;

  // Next-state, counter, write-port and error-strobe decode.
  always_comb begin
    state_n      = state_q;
    len_n        = len_q;
    cols_n       = cols_q;
    byte_cnt_n   = byte_cnt;
    col_cnt_n    = col_cnt;
    wr_en_n      = 1'b0;
    wr_addr_n    = wr_addr;
    wr_data_n    = wr_data;
    col_done_n   = 1'b0;
    col_index_n  = col_index;
    frame_done_n = 1'b0;
    set_len      = 1'b0;
    set_cclk     = 1'b0;
    set_frame    = 1'b0;
    restart      = 1'b0;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        // A FRAME pulse with a zero length or column count is ignored.
        if (FRAME && frame_ok) begin
          restart = 1'b1;
        end
      end

      LOAD: begin
        if (FRAME) begin
          // A new frame start aborts the current frame. The byte in the same
          // cycle belongs to neither frame and is dropped. If the new
          // geometry is zero, no frame can run, so the receiver goes idle.
          set_frame = 1'b1;
          if (frame_ok) begin
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          if (din_valid) begin
            if (byte_cnt < len_q) begin
              wr_en_n    = 1'b1;
              wr_addr_n  = byte_cnt;
              wr_data_n  = din;
              byte_cnt_n = byte_cnt + LEN_W'(1);
            end else begin
              set_len = 1'b1;
            end
          end
          // The length check uses the count that already includes a byte
          // accepted in this same cycle.
          if (cclk_rise) begin
            state_n = CCLK_HI;
            if (byte_cnt_n != len_q) begin
              set_len = 1'b1;
            end
          end
        end
      end

      CCLK_HI: begin
        if (FRAME) begin
          set_frame = 1'b1;
          if (frame_ok) begin
            restart = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else if (cclk_fall) begin
          // A short pulse is flagged, but the column still commits.
          commit      = 1'b1;
          set_cclk    = (int'(cclk_width) < MIN_CCLK);
          col_done_n  = 1'b1;
          col_index_n = col_cnt;
          col_cnt_n   = col_cnt + LEN_W'(1);
          byte_cnt_n  = '0;
          state_n     = (col_cnt_n == cols_q) ? DONE : LOAD;
        end
      end

      DONE: begin
        frame_done_n = 1'b1;
        state_n      = IDLE;
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    if (restart) begin
      len_n      = reg_length;
      cols_n     = reg_cols;
      byte_cnt_n = '0;
      col_cnt_n  = '0;
      state_n    = LOAD;
    end
  end

  // FSM state, latched frame geometry and progress counters.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      len_q    <= '0;
      cols_q   <= '0;
      byte_cnt <= '0;
      col_cnt  <= '0;
    end else begin
      state_q  <= state_n;
      len_q    <= len_n;
      cols_q   <= cols_n;
      byte_cnt <= byte_cnt_n;
      col_cnt  <= col_cnt_n;
    end
  end

  // Registered write port and completion pulses.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      col_done   <= 1'b0;
      col_index  <= '0;
      frame_done <= 1'b0;
    end else begin
      wr_en      <= wr_en_n;
      wr_addr    <= wr_addr_n;
      wr_data    <= wr_data_n;
      col_done   <= col_done_n;
      col_index  <= col_index_n;
      frame_done <= frame_done_n;
    end
  end

  // Sticky error flags: err_clr clears them, but an error raised in the same
  // cycle takes priority over the clear.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_len   <= 1'b0;
      err_cclk  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_len   <= set_len   | (err_len   & ~err_clr);
      err_cclk  <= set_cclk  | (err_cclk  & ~err_clr);
      err_frame <= set_frame | (err_frame & ~err_clr);
    end
  end

`ifdef FRAME_RX_CHECKSUM_EN
  logic [DATA_W-1:0] sum_q;

  // Running XOR of the bytes written into the current column. It is
  // published at commit and restarted for each column or frame.
  always_ff @(posedge ti_clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= '0;
      col_sum <= '0;
    end else begin
      if (commit || restart) begin
        sum_q <= '0;
      end else if (wr_en_n) begin
        sum_q <= sum_q ^ din;
      end
      if (commit) begin
        col_sum <= sum_q;
      end
    end
  end
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// Scoreboard bench for frame_receiver. Stimulus tasks push expected writes,
// column commits and frame completions. A negedge monitor pops and compares
// them whenever the DUT presents an output. Error flags are checked against
// a column-level reference model.
`timescale 1ns/1ps
module tb_frame_receiver;

  localparam int DATA_W   = 8;
  localparam int LEN_W    = 16;
  localparam int MIN_CCLK = 8;
  localparam int EW       = LEN_W + DATA_W;

  // Clock and reset
  logic ti_clk = 1'b0;
  logic rst_n  = 1'b0;
  always #5 ti_clk = ~ti_clk;

  logic [LEN_W-1:0]  reg_length = '0;
  logic [LEN_W-1:0]  reg_cols   = '0;
  logic              FRAME      = 1'b0;
  logic              CCLK       = 1'b0;
  logic [DATA_W-1:0] din        = '0;
  logic              din_valid  = 1'b0;
  logic              err_clr    = 1'b0;
  logic              wr_en, col_done, frame_done, busy;
  logic              err_len, err_cclk, err_frame;
  logic [LEN_W-1:0]  wr_addr, col_index;
  logic [DATA_W-1:0] wr_data;
  logic [1:0]        fsm_state;
`ifdef FRAME_RX_CHECKSUM_EN
  logic [DATA_W-1:0] col_sum;
`endif

  frame_receiver #(.DATA_W(DATA_W), .LEN_W(LEN_W), .MIN_CCLK(MIN_CCLK)) dut (
    .ti_clk     (ti_clk),
    .rst_n      (rst_n),
    .reg_length (reg_length),
    .reg_cols   (reg_cols),
    .FRAME      (FRAME),
    .CCLK       (CCLK),
    .din        (din),
    .din_valid  (din_valid),
    .err_clr    (err_clr),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .col_done   (col_done),
    .col_index  (col_index),
    .frame_done (frame_done),
    .busy       (busy),
    .err_len    (err_len),
    .err_cclk   (err_cclk),
    .err_frame  (err_frame),
    .fsm_state  (fsm_state)
`ifdef FRAME_RX_CHECKSUM_EN
    ,
    .col_sum    (col_sum)
`endif
  );

  // Scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_wr_q[$];   // {addr, data}
  logic [EW-1:0] exp_col_q[$];  // {index, xor of written bytes}
  int exp_frames = 0;
  logic [EW-1:0] mon_e;

  // Reference model: frame/column level view of the receiver
  bit m_busy = 0;
  int m_len = 0, m_cols = 0, m_col = 0;
  bit m_err_len = 0, m_err_cclk = 0, m_err_frame = 0;
  logic [DATA_W-1:0] col_bytes[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ti_clk);
      #1;
    end
  endtask

  // Monitor: compares every DUT output event with the head of its queue
  always @(negedge ti_clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (exp_wr_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL wr_unexpected: got addr %0d data 0x%0h, expected no write", wr_addr, wr_data);
        end else begin
          mon_e = exp_wr_q.pop_front();
          check("wr_addr_data", {40'd0, wr_addr, wr_data}, {40'd0, mon_e});
        end
      end
      if (col_done) begin
        if (exp_col_q.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL col_unexpected: got col_done index %0d, expected none", col_index);
        end else begin
          mon_e = exp_col_q.pop_front();
`ifdef FRAME_RX_CHECKSUM_EN
          check("col_index_sum", {40'd0, col_index, col_sum}, {40'd0, mon_e});
`else
          check("col_index", {48'd0, col_index}, {48'd0, mon_e[EW-1:DATA_W]});
`endif
        end
      end
      if (frame_done) begin
        if (exp_frames == 0) begin
          n_checks++; n_fail++;
          $display("FAIL frame_done_unexpected: got frame_done 1, expected 0");
        end else begin
          exp_frames--;
          n_checks++;
        end
      end
    end
  end

  // Driver tasks
  task automatic fill_bytes(input int n);
    col_bytes.delete();
    repeat (n) col_bytes.push_back(DATA_W'($urandom_range(0, 255)));
  endtask

  task automatic start_frame(input int len, input int cols);
    if (m_busy) m_err_frame = 1;
    if (len != 0 && cols != 0) begin
      m_busy = 1; m_len = len; m_cols = cols; m_col = 0;
    end else if (m_busy) begin
      m_busy = 0;
    end
    reg_length = LEN_W'(len);
    reg_cols   = LEN_W'(cols);
    FRAME      = 1'b1;
    tick();
    FRAME      = 1'b0;
  endtask

  // Sends col_bytes as one column closed by a w-cycle CCLK pulse.
  // merge: last byte shares the CCLK rising cycle; extra_hi: a stray byte
  // while CCLK is high; clr_at_fall: err_clr in the CCLK falling cycle.
  task automatic send_column(input int w, input bit merge, input bit extra_hi, input bit clr_at_fall);
    int n = col_bytes.size();
    int nb;
    logic [DATA_W-1:0] sum = '0;
    for (int i = 0; i < n; i++) begin
      if (i < m_len) begin
        exp_wr_q.push_back({LEN_W'(i), col_bytes[i]});
        sum ^= col_bytes[i];
      end
    end
    if (n != m_len) m_err_len = 1;
    if (clr_at_fall) begin
      m_err_len = 0; m_err_cclk = 0; m_err_frame = 0;
    end
    if (w < MIN_CCLK) m_err_cclk = 1;
    exp_col_q.push_back({LEN_W'(m_col), sum});
    m_col++;
    if (m_col == m_cols) begin
      exp_frames++;
      m_busy = 0;
    end

    nb = (merge && n > 0) ? n - 1 : n;
    for (int i = 0; i < nb; i++) begin
      din = col_bytes[i]; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
      tick($urandom_range(0, 2));
    end
    CCLK = 1'b1;
    if (merge && n > 0) begin
      din = col_bytes[n-1]; din_valid = 1'b1;
    end
    tick();
    din_valid = 1'b0;
    for (int j = 1; j < w; j++) begin
      if (extra_hi && j == 1) begin
        din = DATA_W'($urandom_range(0, 255)); din_valid = 1'b1;
      end
      tick();
      din_valid = 1'b0;
    end
    CCLK = 1'b0;
    err_clr = clr_at_fall;
    tick();
    err_clr = 1'b0;
    tick();
  endtask

  // Sends n bytes of a column that is never closed (n <= latched length)
  task automatic send_partial(input int n);
    fill_bytes(n);
    for (int i = 0; i < n; i++) begin
      exp_wr_q.push_back({LEN_W'(i), col_bytes[i]});
      din = col_bytes[i]; din_valid = 1'b1;
      tick();
      din_valid = 1'b0;
    end
  endtask

  task automatic check_errs(input string tag);
    tick(2);
    check({tag, "_err_len"},   {63'd0, err_len},   {63'd0, m_err_len});
    check({tag, "_err_cclk"},  {63'd0, err_cclk},  {63'd0, m_err_cclk});
    check({tag, "_err_frame"}, {63'd0, err_frame}, {63'd0, m_err_frame});
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err_len = 0; m_err_cclk = 0; m_err_frame = 0;
  endtask

  task automatic run_clean_frame(input int len, input int cols, input int w);
    start_frame(len, cols);
    for (int c = 0; c < cols; c++) begin
      fill_bytes(len);
      send_column(w, 1'b0, 1'b0, 1'b0);
    end
  endtask

  // Watchdog
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Main stimulus
  initial begin
    int len, cols, n, w;
    tick(2);
    // Reset state
    check("rst_wr_en",      {63'd0, wr_en},      64'd0);
    check("rst_wr_addr",    {48'd0, wr_addr},    64'd0);
    check("rst_wr_data",    {56'd0, wr_data},    64'd0);
    check("rst_col_done",   {63'd0, col_done},   64'd0);
    check("rst_col_index",  {48'd0, col_index},  64'd0);
    check("rst_frame_done", {63'd0, frame_done}, 64'd0);
    check("rst_busy",       {63'd0, busy},       64'd0);
    check("rst_errs",       {61'd0, err_len, err_cclk, err_frame}, 64'd0);
    rst_n = 1'b1;
    tick(2);

    // FRAME with a zero length or column count is ignored
    start_frame(0, 3);
    check("zero_len_busy", {63'd0, busy}, 64'd0);
    start_frame(2, 0);
    check("zero_cols_busy", {63'd0, busy}, 64'd0);
    tick(2);

    // Clean frame: len 4, 3 columns, 24-cycle CCLK
    start_frame(4, 3);
    check("frame_busy", {63'd0, busy}, 64'd1);
    for (int c = 0; c < 3; c++) begin
      fill_bytes(4);
      send_column(24, 1'b0, 1'b0, 1'b0);
    end
    check_errs("clean");

    // Short column: 3 of 4 bytes
    start_frame(4, 2);
    fill_bytes(3); send_column(10, 1'b0, 1'b0, 1'b0);
    fill_bytes(4); send_column(10, 1'b0, 1'b0, 1'b0);
    check_errs("short_col");

    // CCLK width boundaries: 8 is legal, 7 and 5 are short
    start_frame(2, 1); fill_bytes(2); send_column(8, 1'b0, 1'b0, 1'b0);
    check_errs("cclk_w8");
    start_frame(2, 1); fill_bytes(2); send_column(7, 1'b0, 1'b0, 1'b0);
    check_errs("cclk_w7");
    start_frame(4, 1); fill_bytes(4); send_column(5, 1'b0, 1'b0, 1'b0);
    check_errs("cclk_w5");

    // Width counter saturates instead of wrapping
    start_frame(1, 1); fill_bytes(1); send_column(260, 1'b0, 1'b0, 1'b0);
    check_errs("cclk_sat");

    // Last byte on the CCLK rising cycle: exact length, then an overrun
    start_frame(4, 2);
    fill_bytes(4); send_column(12, 1'b1, 1'b1, 1'b0);
    fill_bytes(5); send_column(12, 1'b1, 1'b0, 1'b0);
    check_errs("merge");

    // err_clr in the same cycle as a new err_cclk: the new error wins
    start_frame(4, 1); fill_bytes(3); send_column(5, 1'b0, 1'b0, 1'b1);
    check_errs("clr_race");

    // FRAME re-pulsed in the middle of column 1
    start_frame(4, 3);
    fill_bytes(4); send_column(10, 1'b0, 1'b0, 1'b0);
    send_partial(2);
    start_frame(4, 3);
    for (int c = 0; c < 3; c++) begin
      fill_bytes(4);
      send_column(10, 1'b0, 1'b0, 1'b0);
    end
    check_errs("restart");

    // Reset in the middle of LOAD, then a clean frame
    start_frame(4, 2);
    send_partial(2);
    tick();
    rst_n = 1'b0;
    m_busy = 0; m_err_len = 0; m_err_cclk = 0; m_err_frame = 0;
    tick(2);
    check("midrst_busy",     {63'd0, busy},     64'd0);
    check("midrst_col_done", {63'd0, col_done}, 64'd0);
    check("midrst_wr_en",    {63'd0, wr_en},    64'd0);
    rst_n = 1'b1;
    tick();
    run_clean_frame(4, 2, 9);
    check_errs("post_rst");

    // Fixed checksum column 0x12,0x34,0x56,0x78
    start_frame(4, 1);
    col_bytes.delete();
    col_bytes.push_back(8'h12); col_bytes.push_back(8'h34);
    col_bytes.push_back(8'h56); col_bytes.push_back(8'h78);
    send_column(10, 1'b0, 1'b0, 1'b0);
    check_errs("csum");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      len  = $urandom_range(1, 6);
      cols = $urandom_range(1, 3);
      start_frame(len, cols);
      for (int c = 0; c < cols; c++) begin
        n = ($urandom_range(0, 3) == 0) ? $urandom_range(len - 1, len + 1) : len;
        w = $urandom_range(3, 30);
        fill_bytes(n);
        send_column(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      end
      check_errs("rand");
    end

    // Drain and final queue checks
    for (int k = 0; k < 200 && (exp_wr_q.size() != 0 || exp_col_q.size() != 0 || exp_frames != 0); k++) tick();
    check("wr_q_drained",    64'(exp_wr_q.size()),  64'd0);
    check("col_q_drained",   64'(exp_col_q.size()), 64'd0);
    check("frames_drained",  64'(exp_frames),       64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
